pool_window_engine: RTL

POOL_WINDOW_ENGINE -- requirements
Module: pool_window_engine

---
 rtl/pool_pkg.sv | 31 +++
 rtl/pool_sram.sv | 29 ++
 rtl/pool_window_engine.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window engine: operator encoding, FSM
// states and the output-geometry helpers used by the top and the RAMs.
package pool_pkg;

   localparam logic [1:0] MODE_MAX = 2'd0;
   localparam logic [1:0] MODE_MIN = 2'd1;
   localparam logic [1:0] MODE_AVG = 2'd2;
   localparam logic [1:0] MODE_RSV = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_ACC  = 3'd2,
      ST_WR   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   function automatic int out_w_of(int img_w, int k, int stride);
      return (img_w - k) / stride + 1;
   endfunction

   function automatic int out_h_of(int img_h, int k, int stride);
      return (img_h - k) / stride + 1;
   endfunction

   // Address width that never collapses to zero bits for tiny memories.
   function automatic int addr_w(int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/pool_sram.sv
// Single-port RAM with synchronous read; only the read register is reset,
// the storage array keeps its contents across reset.
module pool_sram
   import pool_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata <= '0;
      else       rdata <= mem[addr];
   end

endmodule

// File: rtl/pool_window_engine.sv
// Sliding-window max/min/average pooling over an image held in an internal
// RAM; one pixel is fetched and folded per RD/ACC pair, results go to a second RAM.
module pool_window_engine
   import pool_pkg::*;
#(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int K      = 3,
   parameter int STRIDE = 2,
   parameter int PIX_W  = 8,
   localparam int OUT_W  = out_w_of(IMG_W, K, STRIDE),
   localparam int OUT_H  = out_h_of(IMG_H, K, STRIDE),
   localparam int IN_AW  = addr_w(IMG_W * IMG_H),
   localparam int OUT_AW = addr_w(OUT_W * OUT_H)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              ld_en,
   input  logic [IN_AW-1:0]  ld_addr,
   input  logic [PIX_W-1:0]  ld_data,
   input  logic [OUT_AW-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data,
   output logic              busy,
   output logic              done
);

   localparam int KK    = K * K;
   localparam int ACC_W = PIX_W + $clog2(KK);
   localparam int CW    = $clog2(K + 1);
   localparam int XW    = $clog2(OUT_W + 1);
   localparam int YW    = $clog2(OUT_H + 1);

   state_t            state;
   logic [1:0]        mode_q;
   logic [CW-1:0]     i_q, j_q;
   logic [XW-1:0]     wx_q;
   logic [YW-1:0]     wy_q;
   logic [ACC_W-1:0]  acc, acc_next;
   logic [PIX_W-1:0]  pix, result;

   logic              in_we, out_we;
   logic [IN_AW-1:0]  win_addr, in_addr;
   logic [OUT_AW-1:0] out_wr_addr, out_addr;

   logic first_elem, last_elem, last_col, last_win;

   assign first_elem = (i_q == '0) && (j_q == '0);
   assign last_col   = (i_q == CW'(K - 1));
   assign last_elem  = last_col && (j_q == CW'(K - 1));
   assign last_win   = (wx_q == XW'(OUT_W - 1)) && (wy_q == YW'(OUT_H - 1));

   assign win_addr    = IN_AW'((int'(wy_q) * STRIDE + int'(j_q)) * IMG_W
                               + int'(wx_q) * STRIDE + int'(i_q));
   assign out_wr_addr = OUT_AW'(int'(wy_q) * OUT_W + int'(wx_q));

   // Loads are only honoured while idle so a run always sees a stable image.
   assign in_we    = (state == ST_IDLE) && ld_en;
   assign in_addr  = (state == ST_IDLE) ? ld_addr : win_addr;
   assign out_we   = (state == ST_WR);
   assign out_addr = out_we ? out_wr_addr : rd_addr;

   pool_sram #(.DEPTH(IMG_W * IMG_H), .WIDTH(PIX_W), .AW(IN_AW)) u_in_ram (
      .clk   (clk),
      .reset (reset),
      .we    (in_we),
      .addr  (in_addr),
      .wdata (ld_data),
      .rdata (pix)
   );

   pool_sram #(.DEPTH(OUT_W * OUT_H), .WIDTH(PIX_W), .AW(OUT_AW)) u_out_ram (
      .clk   (clk),
      .reset (reset),
      .we    (out_we),
      .addr  (out_addr),
      .wdata (result),
      .rdata (rd_data)
   );

   // The first element of each window seeds the accumulator instead of folding.
   always_comb begin
      acc_next = acc;
      case (mode_q)
         MODE_MIN: acc_next = (first_elem || pix < acc[PIX_W-1:0]) ? ACC_W'(pix) : acc;
         MODE_AVG: acc_next = first_elem ? ACC_W'(pix) : acc + ACC_W'(pix);
         default:  acc_next = (first_elem || pix > acc[PIX_W-1:0]) ? ACC_W'(pix) : acc;
      endcase
   end

   assign result = (mode_q == MODE_AVG) ? PIX_W'(acc / ACC_W'(KK)) : acc[PIX_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         mode_q <= MODE_MAX;
         i_q    <= '0;
         j_q    <= '0;
         wx_q   <= '0;
         wy_q   <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_RD;
                  mode_q <= mode;
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  i_q    <= '0;
                  j_q    <= '0;
                  wx_q   <= '0;
                  wy_q   <= '0;
               end
            end
            ST_RD: state <= ST_ACC;
            ST_ACC: begin
               acc <= acc_next;
               if (last_elem) begin
                  state <= ST_WR;
                  i_q   <= '0;
                  j_q   <= '0;
               end else begin
                  state <= ST_RD;
                  if (last_col) begin
                     i_q <= '0;
                     j_q <= j_q + 1'b1;
                  end else begin
                     i_q <= i_q + 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (last_win) begin
                  state <= ST_FIN;
                  wx_q  <= '0;
                  wy_q  <= '0;
               end else begin
                  state <= ST_RD;
                  if (wx_q == XW'(OUT_W - 1)) begin
                     wx_q <= '0;
                     wy_q <= wy_q + 1'b1;
                  end else begin
                     wx_q <= wx_q + 1'b1;
                  end
               end
            end
            ST_FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
